// File: rtl/i2c_poll_sequencer.sv
// rtl/i2c_poll_sequencer.sv - polls the switch slave and mirrors its value onto the LED and FND slaves
module i2c_poll_sequencer #(
    parameter int unsigned POLL_CYCLES    = 1000000,
    parameter logic [6:0]  SW_ADDR        = 7'h57,
    parameter logic [6:0]  LED_ADDR       = 7'h55,
    parameter logic [6:0]  FND_ADDR       = 7'h56,
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       m_start,
    output logic       m_rw_bit,
    output logic [6:0] m_slave_addr,
    output logic [7:0] m_tx_data,
    input  logic [7:0] m_rx_data,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_ack_error,
    output logic [7:0] last_sw,
    output logic [7:0] err_count,
    output logic       round_done,
    output logic [2:0] seq_state
);

    localparam int TW = $clog2(POLL_CYCLES + 1);
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(POLL_CYCLES - 1);
    localparam logic [OW-1:0] TO_LAST    = OW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_DONE  = 3'd2,
        S_NEXT       = 3'd3,
        S_WAIT_TIMER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ST_RD_SW  = 2'd0,
        ST_WR_LED = 2'd1,
        ST_WR_FND = 2'd2
    } step_t;

    state_t        state, state_n;
    step_t         step, step_n;
    logic [RW-1:0] retry, retry_n;
    logic [OW-1:0] to_cnt, to_cnt_n;
    logic [TW-1:0] timer, timer_n;
    logic [7:0]    sw, sw_n;
    logic [7:0]    last_sw_q, last_sw_n;
    logic [7:0]    err_q, err_n;
    logic          rw_q, rw_n;
    logic [6:0]    addr_q, addr_n;
    logic [7:0]    tx_q, tx_n;
    logic          rd_ok, rd_ok_n;
    logic          start_c, round_done_c, load;

    // State and datapath registers; reset drops any transfer in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            step      <= ST_RD_SW;
            retry     <= '0;
            to_cnt    <= '0;
            timer     <= '0;
            sw        <= '0;
            last_sw_q <= '0;
            err_q     <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            tx_q      <= '0;
            rd_ok     <= 1'b0;
        end else begin
            state     <= state_n;
            step      <= step_n;
            retry     <= retry_n;
            to_cnt    <= to_cnt_n;
            timer     <= timer_n;
            sw        <= sw_n;
            last_sw_q <= last_sw_n;
            err_q     <= err_n;
            rw_q      <= rw_n;
            addr_q    <= addr_n;
            tx_q      <= tx_n;
            rd_ok     <= rd_ok_n;
        end
    end

    // Next-state logic; command fields are latched on entry to ISSUE so they hold through retries
    always_comb begin
        state_n      = state;
        step_n       = step;
        retry_n      = retry;
        to_cnt_n     = to_cnt;
        timer_n      = timer;
        sw_n         = sw;
        last_sw_n    = last_sw_q;
        err_n        = err_q;
        rw_n         = rw_q;
        addr_n       = addr_q;
        tx_n         = tx_q;
        rd_ok_n      = rd_ok;
        start_c      = 1'b0;
        round_done_c = 1'b0;
        load         = 1'b0;

        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_n = S_ISSUE;
                    step_n  = ST_RD_SW;
                    load    = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!m_busy) begin
                    start_c  = 1'b1;
                    to_cnt_n = '0;
                    state_n  = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                to_cnt_n = to_cnt + 1'b1;
                if (m_done && !m_ack_error) begin
                    if (step == ST_RD_SW) begin
                        sw_n      = m_rx_data;
                        last_sw_n = m_rx_data;
                    end
                    rd_ok_n  = 1'b1;
                    retry_n  = '0;
                    to_cnt_n = '0;
                    state_n  = S_NEXT;
                end else if (m_done || (to_cnt == TO_LAST)) begin
                    to_cnt_n = '0;
                    if (retry < RETRY_MAX) begin
                        retry_n = retry + 1'b1;
                        state_n = S_ISSUE;
                    end else begin
                        if (err_q != 8'hFF) begin
                            err_n = err_q + 1'b1;
                        end
                        rd_ok_n = 1'b0;
                        retry_n = '0;
                        state_n = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if ((step == ST_RD_SW) && rd_ok) begin
                    step_n  = ST_WR_LED;
                    state_n = S_ISSUE;
                    load    = 1'b1;
                end else if (step == ST_WR_LED) begin
                    step_n  = ST_WR_FND;
                    state_n = S_ISSUE;
                    load    = 1'b1;
                end else begin
                    round_done_c = 1'b1;
                    timer_n      = TIMER_LOAD;
                    state_n      = S_WAIT_TIMER;
                end
            end
            S_WAIT_TIMER: begin
                if (!enable) begin
                    state_n = S_IDLE;
                end else if (timer == '0) begin
                    state_n = S_ISSUE;
                    step_n  = ST_RD_SW;
                    load    = 1'b1;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (load) begin
            case (step_n)
                ST_RD_SW: begin
                    rw_n   = 1'b1;
                    addr_n = SW_ADDR;
                    tx_n   = 8'h00;
                end
                ST_WR_LED: begin
                    rw_n   = 1'b0;
                    addr_n = LED_ADDR;
                    tx_n   = sw;
                end
                default: begin
                    rw_n   = 1'b0;
                    addr_n = FND_ADDR;
                    tx_n   = {4'h0, sw[3:0]};
                end
            endcase
        end
    end

    assign m_start      = start_c;
    assign round_done   = round_done_c;
    assign m_rw_bit     = rw_q;
    assign m_slave_addr = addr_q;
    assign m_tx_data    = tx_q;
    assign last_sw      = last_sw_q;
    assign err_count    = err_q;
    assign seq_state    = state;

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// tb/tb_i2c_poll_sequencer.sv - scoreboard bench for i2c_poll_sequencer with a behavioural I2C master
module tb_i2c_poll_sequencer;

    localparam int POLL = 1000;
    localparam int TMO  = 50;

    logic       clk = 1'b0;
    logic       rst, enable;
    logic       m_start, m_rw_bit;
    logic [6:0] m_slave_addr;
    logic [7:0] m_tx_data, m_rx_data;
    logic       m_busy, m_done, m_ack_error;
    logic [7:0] last_sw, err_count;
    logic       round_done;
    logic [2:0] seq_state;

    always #5 clk = ~clk;

    i2c_poll_sequencer #(
        .POLL_CYCLES(POLL),
        .SW_ADDR(7'h57),
        .LED_ADDR(7'h55),
        .FND_ADDR(7'h56),
        .MAX_RETRY(2),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .m_start(m_start),
        .m_rw_bit(m_rw_bit),
        .m_slave_addr(m_slave_addr),
        .m_tx_data(m_tx_data),
        .m_rx_data(m_rx_data),
        .m_busy(m_busy),
        .m_done(m_done),
        .m_ack_error(m_ack_error),
        .last_sw(last_sw),
        .err_count(err_count),
        .round_done(round_done),
        .seq_state(seq_state)
    );

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
    } xfer_t;

    typedef struct {
        logic [7:0] sw;
        logic [7:0] err;
    } rnd_t;

    xfer_t exp_q[$];
    rnd_t  rnd_q[$];
    int    start_cycs[$];
    int    round_cycs[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    logic [7:0] sw_val  = 8'h00;
    logic       nack_sw = 1'b0;
    logic       stall   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push_x(input logic [6:0] a, input logic rw, input logic [7:0] d);
        xfer_t x;
        x.addr = a;
        x.rw   = rw;
        x.data = d;
        exp_q.push_back(x);
    endtask

    task automatic push_r(input logic [7:0] s, input logic [7:0] e);
        rnd_t r;
        r.sw  = s;
        r.err = e;
        rnd_q.push_back(r);
    endtask

    task automatic push_round(input logic [7:0] s, input logic [7:0] e);
        push_x(7'h57, 1'b1, 8'h00);
        push_x(7'h55, 1'b0, s);
        push_x(7'h56, 1'b0, {4'h0, s[3:0]});
        push_r(s, e);
    endtask

    task automatic wait_round(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!round_done && k < 6000);
        if (!round_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_round_timeout: round_done not seen within %0d cycles", tag, k);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_start"}, m_start, 0);
        check({tag, "_m_rw_bit"}, m_rw_bit, 0);
        check({tag, "_m_slave_addr"}, m_slave_addr, 0);
        check({tag, "_m_tx_data"}, m_tx_data, 0);
        check({tag, "_last_sw"}, last_sw, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_round_done"}, round_done, 0);
        check({tag, "_seq_state"}, seq_state, 0);
    endtask

    // Behavioural master: samples m_start at negedge, responds just after the next edge
    logic       start_q = 1'b0;
    logic       pending;
    int         cnt;
    logic [6:0] cap_addr;
    logic       cap_rw;

    always @(negedge clk) start_q = m_start;

    initial begin
        m_busy = 0; m_done = 0; m_ack_error = 0; m_rx_data = 0;
        pending = 0; cnt = 0; cap_addr = 0; cap_rw = 0;
        forever begin
            @(posedge clk);
            #1;
            m_done      = 0;
            m_ack_error = 0;
            if (rst) begin
                pending = 0;
                m_busy  = 0;
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    pending     = 0;
                    m_busy      = 0;
                    m_done      = 1;
                    m_ack_error = nack_sw && (cap_addr == 7'h57);
                    m_rx_data   = cap_rw ? sw_val : 8'h00;
                end
            end else if (start_q && !stall) begin
                pending  = 1;
                m_busy   = 1;
                cnt      = 4;
                cap_addr = m_slave_addr;
                cap_rw   = m_rw_bit;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT issues a transfer or ends a round
    xfer_t      e;
    rnd_t       r;
    logic [6:0] mon_addr = 7'h00;
    always @(negedge clk) begin
        if (!rst) begin
            if (m_start) begin
                start_cycs.push_back(cyc);
                mon_addr = m_slave_addr;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_start: addr %0h rw %0b tx %0h, none expected", m_slave_addr, m_rw_bit, m_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("start_addr", m_slave_addr, e.addr);
                    check("start_rw", m_rw_bit, e.rw);
                    if (!e.rw) check("start_tx", m_tx_data, e.data);
                end
            end
            if (m_done) check("addr_stable_at_done", m_slave_addr, mon_addr);
            if (round_done) begin
                round_cycs.push_back(cyc);
                if (rnd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_round_done: none expected");
                end else begin
                    r = rnd_q.pop_front();
                    check("round_last_sw", last_sw, r.sw);
                    check("round_err_count", err_count, r.err);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        rst = 1; enable = 0; sw_val = 8'hAB;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 0;
        repeat (2) @(negedge clk);
        check("idle_without_enable", seq_state, 0);

        // Round 1: plain mirror of 0xAB
        push_round(8'hAB, 8'h00);
        enable = 1;
        wait_round("r1");

        // Round 2: new switch value, timer spacing
        sw_val = 8'hC5;
        push_round(8'hC5, 8'h00);
        wait_round("r2");
        check("poll_spacing", start_cycs[3] - round_cycs[0], POLL + 1);

        // Round 3: switch slave NACKs every attempt -> no writes
        nack_sw = 1;
        repeat (3) push_x(7'h57, 1'b1, 8'h00);
        push_r(8'hC5, 8'h01);
        wait_round("r3");
        nack_sw = 0;

        // Round 4: master never completes -> timeout retries
        stall = 1;
        repeat (3) push_x(7'h57, 1'b1, 8'h00);
        push_r(8'hC5, 8'h02);
        wait_round("r4");
        stall = 0;
        n = start_cycs.size();
        check("timeout_gap_1", start_cycs[n-2] - start_cycs[n-3], TMO + 1);
        check("timeout_gap_2", start_cycs[n-1] - start_cycs[n-2], TMO + 1);

        // Round 5: drop enable during the LED write
        sw_val = 8'h3C;
        push_round(8'h3C, 8'h02);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(m_start && m_slave_addr == 7'h55) && k < 6000);
        check("led_write_seen", m_start && m_slave_addr == 7'h55, 1);
        enable = 0;
        wait_round("r5");
        repeat (2) @(negedge clk);
        check("idle_after_disable", seq_state, 0);
        repeat (1100) @(negedge clk);
        check("still_idle", seq_state, 0);
        check("no_pending_after_disable", exp_q.size(), 0);

        // Reset during WAIT_DONE, then a full clean round
        sw_val = 8'h5A;
        push_x(7'h57, 1'b1, 8'h00);
        enable = 1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (seq_state != 3'd2 && k < 100);
        check("reached_wait_done", seq_state, 2);
        rst = 1;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 0;
        push_round(8'h5A, 8'h00);
        wait_round("r6");
        enable = 0;
        repeat (5) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("rnd_q_drained", rnd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
